tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1024, cycles tx_start may stay high without tx_ready falling (used only with TX_ARB_TIMEOUT_EN).
REQ-002 sysclk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req  in  4  per-requester byte request; held high with data and last stable until the matching req_ack pulse.
REQ-005 data0..data3  in  8 each  byte offered by requester 0..3.
REQ-006 last  in  4  per-requester flag: offered byte is the final byte of the message.
REQ-007 tx_ready  in  1  serial transmitter status; 1 = idle, 0 = shifting a byte.
REQ-008 tx_start  out  1  start level to the serial transmitter.
REQ-009 tx_data  out  8  byte to the serial transmitter.
REQ-010 req_ack  out  4  one-cycle pulse: owner's current byte accepted by the transmitter.
REQ-011 grant  out  4  one-hot current owner; all zero when unowned.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 timeout_err  out  1  one-cycle pulse on a transmit timeout; present in both builds.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SEND, WAIT; all outputs registered.
REQ-015 IDLE: when tx_ready=1 and any req bit is high, the first requester found scanning upward (mod 4) from rr_ptr SHALL be granted; grant, tx_data (its data), last flag capture and tx_start=1 SHALL appear the next cycle, state SEND.
REQ-016 IDLE with tx_ready=0 SHALL grant nothing and hold.
REQ-017 SEND: tx_start=1, tx_data held constant; on the first cycle tx_ready=0 is sampled, req_ack[owner] SHALL pulse for one cycle, tx_start SHALL drop to 0 the next cycle, state WAIT.
REQ-018 WAIT: on tx_ready=1, if the captured last flag was 1, grant SHALL clear, rr_ptr SHALL become owner+1 (mod 4) and state IDLE.
REQ-019 WAIT: on tx_ready=1 with last flag 0 and req[owner]=1, the new data/last SHALL be latched and state SEND with tx_start=1 next cycle; other requesters SHALL NOT be granted mid-message.
REQ-020 WAIT: on tx_ready=1 with last flag 0 and req[owner]=0, the message SHALL be abandoned: release and rr_ptr advance as in REQ-018.
REQ-021 Requests from non-owners SHALL be ignored (no req_ack) while a message is in progress.
REQ-022 rr_ptr is 2 bits and SHALL wrap 3 -> 0.
REQ-023 Changes on req/data of the owner while in SEND SHALL NOT affect tx_data.

Reset
REQ-024 Assertion of rst_n=0 SHALL immediately force state IDLE, rr_ptr=0, tx_start=0, tx_data=0x00, req_ack=0, grant=0, busy=0, timeout_err=0, timeout counter 0, including mid-byte.
REQ-025 After release, the first grant SHALL need a sysclk edge with rst_n=1 and tx_ready=1.

Configuration
REQ-026 With TX_ARB_TIMEOUT_EN defined, a counter SHALL count SEND cycles; when it reaches TIMEOUT with tx_ready still 1, tx_start SHALL drop, timeout_err SHALL pulse one cycle, no req_ack SHALL pulse, owner SHALL be released and rr_ptr advanced, state IDLE.
REQ-027 Counter SHALL clear on every entry to SEND.
REQ-028 Without TX_ARB_TIMEOUT_EN, SEND SHALL wait indefinitely, no counter SHALL be built and timeout_err SHALL be tied 0.

Verification
REQ-029 Single message: req[1]=1, data1=0x41,0x42 (last on 0x42), transmitter model drops tx_ready 2 cycles after tx_start -> tx_data 0x41 then 0x42, two req_ack[1] pulses, grant=0010 then 0000, rr_ptr=2.
REQ-030 Round-robin: req=1111 all single-byte last=1, start rr_ptr=0 -> grant order 0001,0010,0100,1000,0001.
REQ-031 No interleave: requester 0 sends 3-byte message while req[2]=1 -> requester 2 granted only after requester 0's last byte completes.
REQ-032 Abandon: requester 3 drops req after first non-last byte 0x55 -> release to IDLE, next grant goes to requester 0 when requested.
REQ-033 Reset mid-SEND: rst_n=0 while tx_start=1 -> tx_start, grant, busy zero within the same cycle, no req_ack.
REQ-034 Timeout (TX_ARB_TIMEOUT_EN, TIMEOUT=16): tx_ready held 1 -> timeout_err pulses after 16 SEND cycles, grant clears, no req_ack; without macro tx_start stays 1.

Source files
------------

// File: rtl/tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_arbiter
// Purpose  : Round-robin arbiter that feeds whole multi-byte messages from
//            four requesters into one serial transmitter, without interleaving.
//            Define TX_ARB_TIMEOUT_EN to build the SEND-state timeout.
// Revision : 1.0
// ============================================================================
module tx_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    input  logic [7:0] data3,
    input  logic [3:0] last,
    input  logic       tx_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [3:0] req_ack,
    output logic [3:0] grant,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] rr_ptr;
    logic [1:0] rr_ptr_nxt;
    logic [1:0] owner;
    logic [1:0] owner_nxt;
    logic       last_flag;
    logic       last_flag_nxt;
    logic       tx_start_nxt;
    logic [7:0] tx_data_nxt;
    logic [3:0] req_ack_nxt;
    logic [3:0] grant_nxt;
    logic       busy_nxt;

    logic [7:0] data_sel [4];
    logic [7:0] req_dbl;
    logic [3:0] req_rot;
    logic [1:0] pick_ofs;
    logic [1:0] pick;

    assign data_sel[0] = data0;
    assign data_sel[1] = data1;
    assign data_sel[2] = data2;
    assign data_sel[3] = data3;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    // Rotate requests so bit 0 is the requester at rr_ptr; lowest set bit wins.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[{1'b0, rr_ptr} +: 4];

    always_comb begin
        pick_ofs = 2'd0;
        if (req_rot[0]) begin
            pick_ofs = 2'd0;
        end else if (req_rot[1]) begin
            pick_ofs = 2'd1;
        end else if (req_rot[2]) begin
            pick_ofs = 2'd2;
        end else if (req_rot[3]) begin
            pick_ofs = 2'd3;
        end
    end

    assign pick = rr_ptr + pick_ofs;

`ifdef TX_ARB_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_cnt_nxt;
    logic             timeout_nxt;
    logic             timeout_q;

    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        owner_nxt     = owner;
        last_flag_nxt = last_flag;
        tx_start_nxt  = tx_start;
        tx_data_nxt   = tx_data;
        req_ack_nxt   = 4'b0000;
        grant_nxt     = grant;
`ifdef TX_ARB_TIMEOUT_EN
        tmo_cnt_nxt   = tmo_cnt;
        timeout_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (tx_ready && (|req)) begin
                    owner_nxt     = pick;
                    grant_nxt     = onehot(pick);
                    tx_data_nxt   = data_sel[pick];
                    last_flag_nxt = last[pick];
                    tx_start_nxt  = 1'b1;
                    state_nxt     = SEND;
`ifdef TX_ARB_TIMEOUT_EN
                    tmo_cnt_nxt   = '0;
`endif
                end
            end
            SEND: begin
                if (!tx_ready) begin
                    req_ack_nxt  = onehot(owner);
                    tx_start_nxt = 1'b0;
                    state_nxt    = WAIT;
                end
`ifdef TX_ARB_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    // Transmitter never went busy: give the line up silently.
                    tx_start_nxt = 1'b0;
                    timeout_nxt  = 1'b1;
                    grant_nxt    = 4'b0000;
                    rr_ptr_nxt   = owner + 2'd1;
                    state_nxt    = IDLE;
                end else begin
                    tmo_cnt_nxt  = tmo_cnt + TMO_W'(1);
                end
`endif
            end
            WAIT: begin
                if (tx_ready) begin
                    if (!last_flag && req[owner]) begin
                        tx_data_nxt   = data_sel[owner];
                        last_flag_nxt = last[owner];
                        tx_start_nxt  = 1'b1;
                        state_nxt     = SEND;
`ifdef TX_ARB_TIMEOUT_EN
                        tmo_cnt_nxt   = '0;
`endif
                    end else begin
                        // Message finished or abandoned by its owner.
                        grant_nxt  = 4'b0000;
                        rr_ptr_nxt = owner + 2'd1;
                        state_nxt  = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 2'd0;
            owner     <= 2'd0;
            last_flag <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            req_ack   <= 4'b0000;
            grant     <= 4'b0000;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            owner     <= owner_nxt;
            last_flag <= last_flag_nxt;
            tx_start  <= tx_start_nxt;
            tx_data   <= tx_data_nxt;
            req_ack   <= req_ack_nxt;
            grant     <= grant_nxt;
            busy      <= busy_nxt;
        end
    end

`ifdef TX_ARB_TIMEOUT_EN
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt   <= tmo_cnt_nxt;
            timeout_q <= timeout_nxt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tx_arbiter.sv
`default_nettype none
// Testbench for tx_arbiter: requester and transmitter models around a
// scoreboard of expected (owner, byte) pairs.
module tb_tx_arbiter;
    localparam int TMO = 16;

    logic       sysclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic [3:0] req_b  = 4'b0000;
    logic [7:0] data_b [4];
    logic [3:0] last_b = 4'b0000;
    logic       tx_ready = 1'b1;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [3:0] req_ack;
    logic [3:0] grant;
    logic       busy;
    logic       timeout_err;

    int         n_vec = 0;
    int         n_err = 0;
    logic [9:0] sb [$];
    logic [8:0] rbuf [4][16];
    int         rhead [4];
    int         rtail [4];
    int         ack_total = 0;
    bit         xmit_en = 1'b1;
    int         tx_phase = 0;
    int         tx_cnt = 0;
    logic [1:0] tx_owner = 2'd0;

    always #5 sysclk = ~sysclk;

    tx_arbiter #(.TIMEOUT(TMO)) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .req         (req_b),
        .data0       (data_b[0]),
        .data1       (data_b[1]),
        .data2       (data_b[2]),
        .data3       (data_b[3]),
        .last        (last_b),
        .tx_ready    (tx_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .req_ack     (req_ack),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic offer(input int i, input logic [7:0] d, input logic l);
        if (rhead[i] == rtail[i]) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
        rbuf[i][rtail[i]] = {l, d};
        rtail[i]++;
    endtask

    task automatic expect_byte(input logic [1:0] o, input logic [7:0] d);
        sb.push_back({o, d});
    endtask

    task automatic sync();
        @(posedge sysclk);
        #1;
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int i = 0; i < 4; i++) if (rhead[i] != rtail[i]) e = 1'b0;
        return e && (sb.size() == 0);
    endfunction

    task automatic wait_idle(input string tag);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < 600) begin
            @(negedge sysclk);
            #1;
            n++;
            done = all_empty() && !busy && tx_ready;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Requesters: hold req/data/last on the head byte, advance on req_ack.
    always @(negedge sysclk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst_n && req_ack[i] && (rhead[i] != rtail[i])) rhead[i] = rhead[i] + 1;
            if (rhead[i] != rtail[i]) begin
                req_b[i]  = 1'b1;
                data_b[i] = rbuf[i][rhead[i]][7:0];
                last_b[i] = rbuf[i][rhead[i]][8];
            end else begin
                req_b[i]  = 1'b0;
            end
        end
    end

    // Transmitter: goes busy two cycles after seeing tx_start, busy for four.
    always @(negedge sysclk) begin
        logic [9:0] item;
        if (!rst_n || !xmit_en) begin
            tx_ready = 1'b1;
            tx_phase = 0;
            tx_cnt   = 0;
        end else begin
            case (tx_phase)
                0: if (tx_start) begin
                    tx_phase = 1;
                    tx_cnt   = 0;
                end
                1: begin
                    tx_cnt++;
                    if (tx_cnt == 2) begin
                        check("tx_start_held", tx_start, 1);
                        if (sb.size() == 0) begin
                            check("sb_underflow", 1, 0);
                        end else begin
                            item     = sb.pop_front();
                            tx_owner = item[9:8];
                            check("tx_data", tx_data, item[7:0]);
                            check("grant", grant, 4'b0001 << item[9:8]);
                        end
                        tx_ready = 1'b0;
                        tx_phase = 2;
                        tx_cnt   = 0;
                    end
                end
                2: begin
                    tx_cnt++;
                    if (tx_cnt == 1) begin
                        check("req_ack", req_ack, 4'b0001 << tx_owner);
                        check("tx_start_drop", tx_start, 0);
                    end
                    if (tx_cnt == 4) begin
                        tx_ready = 1'b1;
                        tx_phase = 0;
                    end
                end
                default: tx_phase = 0;
            endcase
        end
    end

    always @(negedge sysclk) if (rst_n) ack_total += $countones(req_ack);

    initial begin
        int n;
        int a0;
        int hi;
        int errs;
        bit seen;
        for (int i = 0; i < 4; i++) begin
            data_b[i] = 8'h00;
            rhead[i]  = 0;
            rtail[i]  = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ack", req_ack, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;

        // Round robin from rr_ptr=0, requester 0 comes back around.
        a0 = ack_total;
        sync();
        offer(0, 8'hA0, 1'b1); offer(0, 8'hA4, 1'b1);
        offer(1, 8'hA1, 1'b1); offer(2, 8'hA2, 1'b1); offer(3, 8'hA3, 1'b1);
        expect_byte(0, 8'hA0); expect_byte(1, 8'hA1); expect_byte(2, 8'hA2);
        expect_byte(3, 8'hA3); expect_byte(0, 8'hA4);
        wait_idle("rr");
        check("rr_acks", ack_total - a0, 5);

        // Two-byte message from requester 1.
        a0 = ack_total;
        sync();
        offer(1, 8'h41, 1'b0); offer(1, 8'h42, 1'b1);
        expect_byte(1, 8'h41); expect_byte(1, 8'h42);
        wait_idle("msg");
        check("msg_acks", ack_total - a0, 2);

        // rr_ptr now 2: requester 2 beats requester 1.
        a0 = ack_total;
        sync();
        offer(1, 8'h61, 1'b1); offer(2, 8'h62, 1'b1);
        expect_byte(2, 8'h62); expect_byte(1, 8'h61);
        wait_idle("ptr");
        check("ptr_acks", ack_total - a0, 2);

        // No interleave: requester 2 arrives mid-message of requester 0.
        a0 = ack_total;
        sync();
        offer(0, 8'h10, 1'b0); offer(0, 8'h11, 1'b0); offer(0, 8'h12, 1'b1);
        expect_byte(0, 8'h10); expect_byte(0, 8'h11); expect_byte(0, 8'h12);
        expect_byte(2, 8'h20);
        n = 0;
        while (grant !== 4'b0001 && n < 60) begin
            @(negedge sysclk);
            #1;
            n++;
        end
        check("ni_first_owner", grant, 4'b0001);
        sync();
        offer(2, 8'h20, 1'b1);
        wait_idle("ni");
        check("ni_acks", ack_total - a0, 4);

        // Abandon: requester 3 drops req after a non-last byte.
        a0 = ack_total;
        sync();
        offer(3, 8'h55, 1'b0);
        expect_byte(3, 8'h55);
        wait_idle("ab");
        check("ab_acks", ack_total - a0, 1);
        a0 = ack_total;
        sync();
        offer(1, 8'h71, 1'b1); offer(3, 8'h73, 1'b1); offer(0, 8'h70, 1'b1);
        expect_byte(0, 8'h70); expect_byte(1, 8'h71); expect_byte(3, 8'h73);
        wait_idle("ab_next");
        check("ab_next_acks", ack_total - a0, 3);

        // Reset while tx_start is high.
        a0 = ack_total;
        sync();
        offer(2, 8'h99, 1'b1);
        n = 0;
        while (tx_start !== 1'b1 && n < 40) begin
            @(negedge sysclk);
            n++;
        end
        check("rs_start_seen", tx_start, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rs_tx_start", tx_start, 0);
        check("rs_grant", grant, 0);
        check("rs_busy", busy, 0);
        check("rs_req_ack", req_ack, 0);
        check("rs_tx_data", tx_data, 0);
        repeat (2) @(posedge sysclk);
        #1;
        rhead[2] = 0;
        rtail[2] = 0;
        @(negedge sysclk);
        sync();
        rst_n = 1'b1;
        repeat (4) sync();
        check("rs_idle_after", busy, 0);
        check("rs_acks", ack_total - a0, 0);

        // Transmitter never goes busy.
        a0 = ack_total;
        sync();
        xmit_en = 1'b0;
        offer(1, 8'h77, 1'b1);
        n = 0;
        while (tx_start !== 1'b1 && n < 40) begin
            @(negedge sysclk);
            #1;
            n++;
        end
        check("to_start_seen", tx_start, 1);
        hi   = 1;
        errs = 0;
`ifdef TX_ARB_TIMEOUT_EN
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 200) begin
            @(negedge sysclk);
            #1;
            n++;
            if (timeout_err) seen = 1'b1;
            else if (tx_start) hi++;
        end
        check("to_err_seen", seen, 1);
        check("to_send_cycles", hi, TMO);
        check("to_grant", grant, 0);
        check("to_tx_start", tx_start, 0);
        check("to_req_ack", req_ack, 0);
`else
        seen = 1'b0;
        repeat (40) begin
            @(negedge sysclk);
            #1;
            if (tx_start) hi++;
            if (timeout_err) errs++;
        end
        check("hold_tx_start", hi, 41);
        check("hold_timeout_err", errs, 0);
        check("hold_grant", grant, 4'b0010);
`endif
        check("to_acks", ack_total - a0, 0);
        rst_n = 1'b0;
        sync();
        rhead[1] = 0;
        rtail[1] = 0;
        xmit_en  = 1'b1;
        @(negedge sysclk);
        sync();
        rst_n = 1'b1;
        repeat (3) sync();

        check("sb_left", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
